// File: rtl/bounce_pkg.sv
// ---------------------------------------------------------------------------
// bounce_pkg : shared types/constants for the bouncing-SR sequencer  (rev 1.0)
// ---------------------------------------------------------------------------
`default_nettype none

package bounce_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int SR_WIDTH    = 8;
  localparam int PRESC_W_DEF = 16;
  localparam int CNT_W_DEF   = 8;

endpackage

`default_nettype wire

// File: rtl/bounce_seq_ctrl_if.sv
// ---------------------------------------------------------------------------
// bounce_seq_ctrl_if : controller/shift-register side signals  (rev 1.0)
// ---------------------------------------------------------------------------
`default_nettype none

interface bounce_seq_ctrl_if
  import bounce_pkg::*;
#(
  parameter int PRESC_W = PRESC_W_DEF,
  parameter int CNT_W   = CNT_W_DEF
) ();

  logic               start;
  logic               stop;
  logic               pause;
  logic [PRESC_W-1:0] presc_div;
  logic [CNT_W-1:0]   num_sweeps;
  logic               tc_in;
  logic               sr_ena;
  logic               busy;
  logic               done;
  logic [CNT_W-1:0]   sweep_cnt;
  logic               fault;

  modport master (
    output start, stop, pause, presc_div, num_sweeps, tc_in,
    input  sr_ena, busy, done, sweep_cnt, fault
  );

  modport slave (
    input  start, stop, pause, presc_div, num_sweeps, tc_in,
    output sr_ena, busy, done, sweep_cnt, fault
  );

endinterface

`default_nettype wire

// File: rtl/bounce_presc.sv
// ---------------------------------------------------------------------------
// bounce_presc : free-running divider producing one tick per div cycles  (rev 1.0)
// ---------------------------------------------------------------------------
`default_nettype none

module bounce_presc #(
  parameter int PRESC_W = 16
) (
  input  wire logic               clk,
  input  wire logic               rstna,
  input  wire logic               clr,
  input  wire logic               run,
  input  wire logic [PRESC_W-1:0] div,
  output logic                    tick
);

  logic [PRESC_W-1:0] div_eff;
  logic [PRESC_W-1:0] cnt;
  logic               at_last;

  // A divider of 0 behaves as 1 so the strobe can never stall.
  assign div_eff = (div == '0) ? PRESC_W'(1) : div;
  assign at_last = (cnt == (div_eff - PRESC_W'(1)));
  assign tick    = run & at_last;

  always_ff @(posedge clk or negedge rstna) begin
    if (!rstna) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (run) begin
      cnt <= at_last ? '0 : cnt + PRESC_W'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/bounce_seq_ctrl.sv
// ---------------------------------------------------------------------------
// bounce_seq_ctrl : strobe/sweep sequencer for the bouncing one-hot SR  (rev 1.0)
// Optional watchdog: define BOUNCE_SEQ_CTRL_WDOG_EN.
// ---------------------------------------------------------------------------
`default_nettype none

module bounce_seq_ctrl
  import bounce_pkg::*;
#(
  parameter int PRESC_W = PRESC_W_DEF,
  parameter int CNT_W   = CNT_W_DEF
`ifdef BOUNCE_SEQ_CTRL_WDOG_EN
  ,
  parameter int WDOG_LIM = 64
`endif
) (
  input wire logic          clk,
  input wire logic          rstna,
  bounce_seq_ctrl_if.slave  bus
);

  state_t             state, state_nx;
  logic [PRESC_W-1:0] div_q;
  logic [CNT_W-1:0]   target_q;
  logic [CNT_W-1:0]   sweep_cnt_r;
  logic               tc_q;
  logic               sr_ena_r, busy_r, done_r;

  logic               active, tc_rise, cnt_edge, hit, start_ok;
  logic               presc_run, tick, strobe_nx;
  logic [CNT_W-1:0]   cnt_inc;
  logic               wdog_trip, fault_w;

  assign active   = (state == RUN) || (state == PAUSE);
  assign tc_rise  = bus.tc_in & ~tc_q;
  assign cnt_edge = tc_rise & active;
  assign cnt_inc  = (&sweep_cnt_r) ? sweep_cnt_r : sweep_cnt_r + CNT_W'(1);
  assign hit      = cnt_edge & (target_q != '0) & (cnt_inc == target_q);
  assign start_ok = (state == IDLE) & bus.start & ~bus.stop & ~fault_w;
  // Prescaler freezes the same cycle stop/pause is seen, so no count is lost.
  assign presc_run = (state == RUN) & ~bus.stop & ~bus.pause;

  bounce_presc #(.PRESC_W(PRESC_W)) u_presc (
    .clk   (clk),
    .rstna (rstna),
    .clr   (start_ok),
    .run   (presc_run),
    .div   (div_q),
    .tick  (tick)
  );

  always_comb begin
    state_nx  = state;
    strobe_nx = 1'b0;
    case (state)
      IDLE:  if (start_ok) state_nx = RUN;
      RUN: begin
        if (bus.stop)        state_nx = IDLE;
        else if (hit)        state_nx = DONE;
        else if (wdog_trip)  state_nx = IDLE;
        else if (bus.pause)  state_nx = PAUSE;
        else                 strobe_nx = tick;
      end
      PAUSE: begin
        if (bus.stop)        state_nx = IDLE;
        else if (hit)        state_nx = DONE;
        else if (wdog_trip)  state_nx = IDLE;
        else if (!bus.pause) state_nx = RUN;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstna) begin
    if (!rstna) begin
      state       <= IDLE;
      tc_q        <= 1'b0;
      sr_ena_r    <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      div_q       <= '0;
      target_q    <= '0;
      sweep_cnt_r <= '0;
    end else begin
      state    <= state_nx;
      tc_q     <= bus.tc_in;
      sr_ena_r <= strobe_nx;
      busy_r   <= (state_nx == RUN) || (state_nx == PAUSE);
      done_r   <= (state_nx == DONE);
      if (start_ok) begin
        div_q       <= bus.presc_div;
        target_q    <= bus.num_sweeps;
        sweep_cnt_r <= '0;
      end else if (cnt_edge) begin
        sweep_cnt_r <= cnt_inc;
      end
    end
  end

`ifdef BOUNCE_SEQ_CTRL_WDOG_EN
  localparam int WD_W = $clog2(WDOG_LIM + 1);

  logic [WD_W-1:0] wdog_cnt;
  logic            fault_r;

  assign wdog_trip = active & (wdog_cnt == WD_W'(WDOG_LIM));
  assign fault_w   = fault_r;

  always_ff @(posedge clk or negedge rstna) begin
    if (!rstna) begin
      wdog_cnt <= '0;
      fault_r  <= 1'b0;
    end else begin
      if (start_ok || tc_rise) wdog_cnt <= '0;
      else if (strobe_nx)      wdog_cnt <= wdog_cnt + WD_W'(1);
      if (wdog_trip && !bus.stop && !hit) fault_r <= 1'b1;
    end
  end
`else
  assign wdog_trip = 1'b0;
  assign fault_w   = 1'b0;
`endif

  assign bus.sr_ena    = sr_ena_r;
  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.sweep_cnt = sweep_cnt_r;
  assign bus.fault     = fault_w;

endmodule

`default_nettype wire

// File: tb/tb_bounce_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_bounce_seq_ctrl : directed self-checking bench for bounce_seq_ctrl  (rev 1.0)
// ---------------------------------------------------------------------------
`default_nettype none

module tb_bounce_seq_ctrl;

  logic clk   = 1'b0;
  logic rstna = 1'b0;
  always #5 clk = ~clk;

  bounce_seq_ctrl_if #(.PRESC_W(16), .CNT_W(8)) bus ();

  bounce_seq_ctrl #(.PRESC_W(16), .CNT_W(8)) dut (
    .clk   (clk),
    .rstna (rstna),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  bit use_model = 1'b0;
  int pos       = 0;
  bit dir_dn    = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_tests++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic outs(input string tag, input logic sr, input logic bz,
                      input logic dn, input logic [7:0] cnt);
    chk($sformatf("%s.c%0d.sr_ena", tag, cyc), {31'd0, bus.sr_ena}, {31'd0, sr});
    chk($sformatf("%s.c%0d.busy", tag, cyc), {31'd0, bus.busy}, {31'd0, bz});
    chk($sformatf("%s.c%0d.done", tag, cyc), {31'd0, bus.done}, {31'd0, dn});
    chk($sformatf("%s.c%0d.sweep_cnt", tag, cyc), {24'd0, bus.sweep_cnt}, {24'd0, cnt});
  endtask

  // One clock: the bouncing-SR model shifts on the strobe it saw at the edge.
  task automatic step();
    logic pre;
    pre = bus.sr_ena;
    @(posedge clk);
    if (use_model && pre) begin
      if (!dir_dn) begin
        pos++;
        if (pos == 7) dir_dn = 1'b1;
      end else begin
        pos--;
        if (pos == 0) dir_dn = 1'b0;
      end
    end
    #1;
    if (use_model) bus.tc_in = (pos == 7);
    cyc++;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: observed no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    bus.start = 1'b0; bus.stop = 1'b0; bus.pause = 1'b0;
    bus.presc_div = '0; bus.num_sweeps = '0; bus.tc_in = 1'b0;

    #12;
    outs("reset", 1'b0, 1'b0, 1'b0, 8'd0);
    chk("reset.fault", {31'd0, bus.fault}, 32'd0);
    rstna = 1'b1;
    step(); step();

    // div=4, two sweeps, tc from a bouncing SR model
    bus.presc_div = 16'd4; bus.num_sweeps = 8'd2; bus.start = 1'b1;
    pos = 0; dir_dn = 1'b0; use_model = 1'b1; cyc = 0;
    repeat (95) begin
      step();
      if (cyc == 1) bus.start = 1'b0;
      outs("sweep2", (cyc >= 5) && (cyc <= 85) && (cyc % 4 == 1), cyc <= 86, cyc == 87,
           (cyc < 31) ? 8'd0 : (cyc < 87) ? 8'd1 : 8'd2);
    end
    use_model = 1'b0; bus.tc_in = 1'b0;
    step(); step();

    // div=0 (acts as 1), endless run, tc held 5 cycles, stop at 100
    bus.presc_div = 16'd0; bus.num_sweeps = 8'd0; bus.start = 1'b1; cyc = 0;
    repeat (105) begin
      step();
      outs("endless", (cyc >= 2) && (cyc <= 100), cyc <= 100, 1'b0,
           (cyc < 11) ? 8'd0 : (cyc < 41) ? 8'd1 : 8'd2);
      if (cyc == 1)   bus.start = 1'b0;
      if (cyc == 10)  bus.tc_in = 1'b1;
      if (cyc == 15)  bus.tc_in = 1'b0;
      if (cyc == 40)  bus.tc_in = 1'b1;
      if (cyc == 41)  bus.tc_in = 1'b0;
      if (cyc == 100) bus.stop  = 1'b1;
      if (cyc == 102) bus.stop  = 1'b0;
    end

    // div=5, pause while prescaler sits at 2 for 10 cycles
    bus.presc_div = 16'd5; bus.start = 1'b1; cyc = 0;
    repeat (24) begin
      step();
      outs("pause", (cyc == 17) || (cyc == 22), 1'b1, 1'b0, 8'd0);
      if (cyc == 1)  bus.start = 1'b0;
      if (cyc == 3)  bus.pause = 1'b1;
      if (cyc == 13) bus.pause = 1'b0;
    end
    bus.stop = 1'b1; step(); bus.stop = 1'b0;
    outs("pause_stop", 1'b0, 1'b0, 1'b0, 8'd0);

    // stop coincides with the target edge: count, but no done
    bus.presc_div = 16'd1; bus.num_sweeps = 8'd1; bus.start = 1'b1; cyc = 0;
    step(); bus.start = 1'b0;
    repeat (4) step();
    outs("stop_tgt_pre", 1'b1, 1'b1, 1'b0, 8'd0);
    bus.tc_in = 1'b1; bus.stop = 1'b1;
    step();
    outs("stop_tgt", 1'b0, 1'b0, 1'b0, 8'd1);
    bus.tc_in = 1'b0; bus.stop = 1'b0;
    step();
    outs("stop_tgt_after", 1'b0, 1'b0, 1'b0, 8'd1);

    // pause coincides with the target edge: done wins; start held re-arms
    bus.start = 1'b1; cyc = 0;
    repeat (5) step();
    bus.pause = 1'b1; bus.tc_in = 1'b1;
    step();
    outs("pause_tgt", 1'b0, 1'b0, 1'b1, 8'd1);
    bus.pause = 1'b0; bus.tc_in = 1'b0;
    step();
    outs("pause_tgt_idle", 1'b0, 1'b0, 1'b0, 8'd1);
    step();
    outs("rearm", 1'b0, 1'b1, 1'b0, 8'd0);
    bus.start = 1'b0; bus.stop = 1'b1; step(); bus.stop = 1'b0;

    // asynchronous reset mid-run, then restart
    bus.presc_div = 16'd3; bus.num_sweeps = 8'd0; bus.start = 1'b1; cyc = 0;
    step(); bus.start = 1'b0;
    step(); bus.tc_in = 1'b1;
    step(); bus.tc_in = 1'b0;
    step();
    outs("pre_rst", 1'b1, 1'b1, 1'b0, 8'd1);
    #2 rstna = 1'b0;
    #1 outs("async_rst", 1'b0, 1'b0, 1'b0, 8'd0);
    @(negedge clk); rstna = 1'b1;
    step();
    bus.start = 1'b1; cyc = 0;
    step(); bus.start = 1'b0;
    outs("restart", 1'b0, 1'b1, 1'b0, 8'd0);
    step(); step();
    outs("restart", 1'b0, 1'b1, 1'b0, 8'd0);
    step();
    outs("restart", 1'b1, 1'b1, 1'b0, 8'd0);
    bus.stop = 1'b1; step(); bus.stop = 1'b0;

`ifdef BOUNCE_SEQ_CTRL_WDOG_EN
    // watchdog: no TC edges, div=1 -> fault after 64 strobes
    bus.presc_div = 16'd1; bus.num_sweeps = 8'd0; bus.start = 1'b1; cyc = 0;
    repeat (66) begin
      step();
      if (cyc == 1) bus.start = 1'b0;
      if (cyc == 65) begin
        chk("wdog.pre_fault", {31'd0, bus.fault}, 32'd0);
        chk("wdog.pre_busy", {31'd0, bus.busy}, 32'd1);
      end
    end
    chk("wdog.fault", {31'd0, bus.fault}, 32'd1);
    chk("wdog.busy", {31'd0, bus.busy}, 32'd0);
    chk("wdog.done", {31'd0, bus.done}, 32'd0);
    bus.start = 1'b1;
    repeat (5) step();
    chk("wdog.blocked", {31'd0, bus.busy}, 32'd0);
    bus.start = 1'b0;
    rstna = 1'b0; #1;
    chk("wdog.cleared", {31'd0, bus.fault}, 32'd0);
    @(negedge clk); rstna = 1'b1;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
